// File: rtl/swap_pkg.sv
// Types and default constants shared by the swap request initiator and the swap executor.
package swap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_ISSUE      = 2'b01,
        ST_WAIT_START = 2'b10,
        ST_BURST      = 2'b11
    } swap_state_e;

    // The executor's write burst is three cycles long (its s1..s3 sequence).
    localparam int SWAP_CYC_DEFAULT = 3;
    localparam int START_TO_DEFAULT = 2;
    localparam int SWAP_AW          = 4;

    typedef struct packed {
        logic [SWAP_AW-1:0] addr_a;
        logic [SWAP_AW-1:0] addr_b;
    } addr_pair_t;

endpackage

// File: rtl/swap_req_fifo.sv
// Request FIFO for the swap initiator: power-of-2 depth, registered read, occupancy count.
module swap_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] rdata_reg;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && (count_reg != CW'(DEPTH));
    assign pop_ok  = pop && (count_reg != '0);

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers are exactly PW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            rdata_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                rdata_reg  <= mem[rd_ptr_reg];
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: ;
            endcase
        end
    end

    assign rdata = rdata_reg;
    assign count = count_reg;

endmodule

// File: rtl/swap_req_issuer.sv
// Initiator side of the memory-swap handshake: queues address pairs and issues them one
// at a time to the swap executor, watching its write burst for completion and protocol errors.
module swap_req_issuer
    import swap_pkg::*;
#(
    parameter int AW       = SWAP_AW,
    parameter int DEPTH    = 4,
    parameter int SWAP_CYC = SWAP_CYC_DEFAULT,
    parameter int START_TO = START_TO_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [AW-1:0]          req_addr_a,
    input  logic [AW-1:0]          req_addr_b,
    output logic                   swap,
    output logic [AW-1:0]          addr_a,
    output logic [AW-1:0]          addr_b,
    input  logic                   w,
    output logic                   done,
    output logic                   err,
    output logic [$clog2(DEPTH):0] pending
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(SWAP_CYC + 2);
    localparam int TW = $clog2(START_TO + 1);

    localparam logic [1:0] IDLE       = ST_IDLE;
    localparam logic [1:0] ISSUE      = ST_ISSUE;
    localparam logic [1:0] WAIT_START = ST_WAIT_START;
    localparam logic [1:0] BURST      = ST_BURST;

    logic [1:0]      state_reg;
    logic [1:0]      state_next;
    logic [BW-1:0]   burst_cnt_reg;
    logic [BW-1:0]   burst_cnt_next;
    logic [TW-1:0]   to_cnt_reg;
    logic [TW-1:0]   to_cnt_next;
    logic            err_reg;
    logic            err_hit;
    logic            err_set;
    logic            done_hit;
    logic            fifo_push;
    logic            fifo_pop;
    logic [2*AW-1:0] fifo_rdata;
    logic [CW-1:0]   fifo_count;

    // Ready comes only from the registered count, so a pop never opens ready in the same cycle.
    assign req_ready = (fifo_count != CW'(DEPTH));
    assign fifo_push = req_valid && req_ready && (req_addr_a != req_addr_b);
    assign fifo_pop  = (state_reg == IDLE) && (fifo_count != '0);

    swap_req_fifo #(
        .WIDTH (2 * AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({req_addr_a, req_addr_b}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    always_comb begin
        state_next     = state_reg;
        burst_cnt_next = burst_cnt_reg;
        to_cnt_next    = to_cnt_reg;
        err_hit        = 1'b0;
        done_hit       = 1'b0;
        case (state_reg)
            IDLE: begin
                err_hit = w;
                if (fifo_pop) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                err_hit     = w;
                to_cnt_next = '0;
                state_next  = WAIT_START;
            end
            WAIT_START: begin
                if (w) begin
                    burst_cnt_next = BW'(1);
                    state_next     = BURST;
                end else if (to_cnt_reg == TW'(START_TO - 1)) begin
                    err_hit    = 1'b1;
                    state_next = IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end
            BURST: begin
                if (w) begin
                    // Saturate one past the legal length so an overlong burst stays visible.
                    if (burst_cnt_reg != BW'(SWAP_CYC + 1)) begin
                        burst_cnt_next = burst_cnt_reg + 1'b1;
                    end
                end else begin
                    done_hit   = 1'b1;
                    err_hit    = (burst_cnt_reg != BW'(SWAP_CYC));
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A reset cycle must never produce a done pulse or a fresh error.
    assign err_set = err_hit && !rst;
    assign done    = done_hit && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            burst_cnt_reg <= '0;
            to_cnt_reg    <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            burst_cnt_reg <= burst_cnt_next;
            to_cnt_reg    <= to_cnt_next;
            err_reg       <= err_reg | err_set;
        end
    end

    // The FIFO read register only loads on an IDLE pop, so it doubles as the held operand pair.
    assign swap    = (state_reg == ISSUE);
    assign addr_a  = fifo_rdata[2*AW-1:AW];
    assign addr_b  = fifo_rdata[AW-1:0];
    assign err     = err_reg | err_set;
    assign pending = fifo_count;

endmodule

// File: tb/tb_swap_req_issuer.sv
// Directed bench for swap_req_issuer: single-request vector table plus multi-cycle sequences.
module tb_swap_req_issuer;
    import swap_pkg::*;

    localparam int AW    = 4;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   req_valid = 1'b0;
    logic                   req_ready;
    logic [AW-1:0]          req_addr_a = '0;
    logic [AW-1:0]          req_addr_b = '0;
    logic                   swap;
    logic [AW-1:0]          addr_a;
    logic [AW-1:0]          addr_b;
    logic                   w = 1'b0;
    logic                   done;
    logic                   err;
    logic [$clog2(DEPTH):0] pending;

    swap_req_issuer #(
        .AW       (AW),
        .DEPTH    (DEPTH),
        .SWAP_CYC (3),
        .START_TO (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr_a (req_addr_a),
        .req_addr_b (req_addr_b),
        .swap       (swap),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .w          (w),
        .done       (done),
        .err        (err),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Executor model: after seeing swap, holds w high for exec_len cycles.
    int exec_len  = 3;
    int exec_rem  = 0;
    bit exec_kill = 1'b0;
    bit swap_seen = 1'b0;

    // Monitor records
    int            swap_cyc_q[$];
    int            swap_a_q[$];
    int            swap_b_q[$];
    int            done_cyc_q[$];
    int            err_rise_cyc = -1;
    int            stab_err = 0;
    bit            in_op = 1'b0;
    logic [AW-1:0] op_a = '0;
    logic [AW-1:0] op_b = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (swap_seen) exec_rem = exec_len;
        if (exec_kill) exec_rem = 0;
        w = (exec_rem > 0);
        if (exec_rem > 0) exec_rem = exec_rem - 1;
    end

    initial forever begin
        @(negedge clk);
        swap_seen = (swap === 1'b1);
        if (swap === 1'b1) begin
            swap_cyc_q.push_back(cyc);
            swap_a_q.push_back(int'(addr_a));
            swap_b_q.push_back(int'(addr_b));
            in_op = 1'b1;
            op_a  = addr_a;
            op_b  = addr_b;
        end else if (in_op && (addr_a !== op_a || addr_b !== op_b)) begin
            stab_err++;
        end
        if (done === 1'b1) begin
            done_cyc_q.push_back(cyc);
            in_op = 1'b0;
        end
        if (err === 1'b1 && err_rise_cyc < 0) begin
            err_rise_cyc = cyc;
            in_op = 1'b0;
        end
        if (rst) in_op = 1'b0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_mon();
        swap_cyc_q.delete();
        swap_a_q.delete();
        swap_b_q.delete();
        done_cyc_q.delete();
        err_rise_cyc = -1;
        stab_err = 0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        exec_kill = 1'b1;
        req_valid = 1'b0;
        step(2);
        rst = 1'b0;
        exec_kill = 1'b0;
        clear_mon();
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [AW-1:0] b, output int waits);
        logic acc;
        waits = 0;
        req_valid  = 1'b1;
        req_addr_a = a;
        req_addr_b = b;
        forever begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #2;
            if (acc === 1'b1) break;
            waits++;
            if (waits > 200) begin
                chk("push_timeout", 1, 0);
                break;
            end
        end
        req_valid = 1'b0;
        $display("push a=%0d b=%0d waits=%0d", a, b, waits);
    endtask

    typedef struct {
        addr_pair_t pair;
        int         len;
        int         exp_swaps;
        int         exp_done_off;
        int         exp_err_off;
        logic       exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int wt;
        int exp_a[6];
        int exp_b[6];

        // Single-request vectors; offsets are cycles after the swap pulse, -1 means never.
        vecs[0] = '{'{4'd3,  4'd9}, 3, 1,  4, -1, 1'b0};
        vecs[1] = '{'{4'd7,  4'd7}, 3, 0, -1, -1, 1'b0};
        vecs[2] = '{'{4'd1,  4'd2}, 0, 1, -1,  2, 1'b1};
        vecs[3] = '{'{4'd5,  4'd6}, 2, 1,  3,  3, 1'b1};
        vecs[4] = '{'{4'd10, 4'd4}, 4, 1,  5,  5, 1'b1};
        vecs[5] = '{'{4'd15, 4'd0}, 3, 1,  4, -1, 1'b0};

        // Reset state
        rst = 1'b1;
        exec_kill = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_swap",    32'(swap),    0);
        chk("rst_done",    32'(done),    0);
        chk("rst_err",     32'(err),     0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_addr_a",  32'(addr_a),  0);
        chk("rst_addr_b",  32'(addr_b),  0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        exec_kill = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", 32'(req_ready), 1);

        // Table of single requests
        for (int i = 0; i < 6; i++) begin
            reset_dut();
            exec_len = vecs[i].len;
            push(vecs[i].pair.addr_a, vecs[i].pair.addr_b, wt);
            step(20);
            $display("vec %0d: swaps=%0d dones=%0d err=%0b", i, swap_cyc_q.size(),
                     done_cyc_q.size(), err);
            chk($sformatf("v%0d_swaps", i), swap_cyc_q.size(), vecs[i].exp_swaps);
            if (vecs[i].exp_swaps > 0 && swap_cyc_q.size() > 0) begin
                chk($sformatf("v%0d_addr_a", i), swap_a_q[0], 32'(vecs[i].pair.addr_a));
                chk($sformatf("v%0d_addr_b", i), swap_b_q[0], 32'(vecs[i].pair.addr_b));
            end
            chk($sformatf("v%0d_dones", i), done_cyc_q.size(),
                (vecs[i].exp_done_off >= 0) ? 1 : 0);
            if (vecs[i].exp_done_off >= 0 && done_cyc_q.size() > 0 && swap_cyc_q.size() > 0)
                chk($sformatf("v%0d_done_off", i), done_cyc_q[0] - swap_cyc_q[0],
                    vecs[i].exp_done_off);
            if (vecs[i].exp_err_off >= 0 && swap_cyc_q.size() > 0)
                chk($sformatf("v%0d_err_off", i), err_rise_cyc - swap_cyc_q[0],
                    vecs[i].exp_err_off);
            else
                chk($sformatf("v%0d_no_err", i), err_rise_cyc, -1);
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_pending", i), 32'(pending), 0);
            chk($sformatf("v%0d_stable", i), stab_err, 0);
        end

        // Equal-address request dropped, following request issued
        reset_dut();
        exec_len = 3;
        push(4'd7, 4'd7, wt);
        push(4'd1, 4'd2, wt);
        step(20);
        $display("eq seq: swaps=%0d dones=%0d", swap_cyc_q.size(), done_cyc_q.size());
        chk("eq_swaps", swap_cyc_q.size(), 1);
        if (swap_cyc_q.size() > 0) begin
            chk("eq_addr_a", swap_a_q[0], 1);
            chk("eq_addr_b", swap_b_q[0], 2);
        end
        chk("eq_dones", done_cyc_q.size(), 1);
        chk("eq_err", 32'(err), 0);

        // FIFO fill behind a stalled executor, then drain in order
        reset_dut();
        exec_len = 12;
        exp_a = '{14, 1, 2, 3, 4, 5};
        exp_b = '{15, 8, 9, 10, 11, 12};
        push(4'd14, 4'd15, wt);
        push(4'd1, 4'd8, wt);
        chk("fill_r1_wait", wt, 0);
        push(4'd2, 4'd9, wt);
        exec_len = 3;
        push(4'd3, 4'd10, wt);
        push(4'd4, 4'd11, wt);
        chk("fill_r4_wait", wt, 0);
        @(negedge clk);
        chk("fill_pending_full", 32'(pending), 4);
        chk("fill_ready_low", 32'(req_ready), 0);
        push(4'd5, 4'd12, wt);
        chk("fill_r5_held", (wt > 0) ? 1 : 0, 1);
        step(60);
        $display("fill seq: swaps=%0d dones=%0d", swap_cyc_q.size(), done_cyc_q.size());
        chk("fill_swaps", swap_cyc_q.size(), 6);
        chk("fill_dones", done_cyc_q.size(), 6);
        if (swap_cyc_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("fill_order_a%0d", i), swap_a_q[i], exp_a[i]);
                chk($sformatf("fill_order_b%0d", i), swap_b_q[i], exp_b[i]);
            end
            for (int i = 1; i < 5; i++)
                chk($sformatf("fill_spacing%0d", i), swap_cyc_q[i+1] - swap_cyc_q[i], 6);
        end
        chk("fill_pending_end", 32'(pending), 0);
        chk("fill_stable", stab_err, 0);
        chk("fill_err_long", 32'(err), 1);

        // Start timeout, next request still issues
        reset_dut();
        exec_len = 0;
        push(4'd1, 4'd2, wt);
        push(4'd3, 4'd4, wt);
        step(2);
        exec_len = 3;
        step(30);
        $display("timeout seq: swaps=%0d dones=%0d err_rise=%0d", swap_cyc_q.size(),
                 done_cyc_q.size(), err_rise_cyc);
        chk("to_swaps", swap_cyc_q.size(), 2);
        chk("to_dones", done_cyc_q.size(), 1);
        if (swap_cyc_q.size() == 2) begin
            chk("to_err_off", err_rise_cyc - swap_cyc_q[0], 2);
            chk("to_next_swap", swap_cyc_q[1] - swap_cyc_q[0], 4);
            chk("to_second_a", swap_a_q[1], 3);
            chk("to_second_b", swap_b_q[1], 4);
            if (done_cyc_q.size() == 1)
                chk("to_done_off", done_cyc_q[0] - swap_cyc_q[1], 4);
        end
        chk("to_err_sticky", 32'(err), 1);
        chk("to_pending", 32'(pending), 0);

        // Reset during BURST with two requests queued
        reset_dut();
        exec_len = 3;
        push(4'd1, 4'd2, wt);
        push(4'd3, 4'd4, wt);
        push(4'd5, 4'd6, wt);
        step(1);
        @(negedge clk);
        chk("mid_pending_before", 32'(pending), 2);
        chk("mid_burst_w", 32'(w), 1);
        rst = 1'b1;
        exec_kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_swap",    32'(swap),    0);
        chk("mid_done",    32'(done),    0);
        chk("mid_err",     32'(err),     0);
        chk("mid_pending", 32'(pending), 0);
        chk("mid_addr_a",  32'(addr_a),  0);
        chk("mid_addr_b",  32'(addr_b),  0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        exec_kill = 1'b0;
        step(20);
        $display("reset seq: swaps=%0d dones=%0d", swap_cyc_q.size(), done_cyc_q.size());
        chk("mid_swaps_total", swap_cyc_q.size(), 1);
        chk("mid_no_done", done_cyc_q.size(), 0);
        chk("mid_no_err", err_rise_cyc, -1);
        chk("mid_pending_end", 32'(pending), 0);
        chk("mid_ready_end", 32'(req_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
